// File: rtl/sha_pkg.sv
// Shared types for the SHA-256 core input path: frame layout, word helpers.
// Used by the loader RTL, the golden model and the bench.
package sha_pkg;
  localparam int WORD_W      = 32;
  localparam int FRAME_WORDS = 11;
  localparam int IDX_W       = 4;

  typedef logic [WORD_W-1:0] word_t;

  // Field order makes 'a' the MSBs of the packed state.
  typedef struct packed {
    word_t a, b, c, d, e, f, g, h;
  } hash_state_t;

  typedef struct packed {
    hash_state_t hs;
    word_t       w1, w2, w3;
  } frame_t;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_FILL = 2'd1,
    LD_FULL = 2'd2
  } load_state_e;

  function automatic word_t little_endian_to_big(input word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/core_input_loader_if.sv
// Load-side word stream and core-side frame bundle of the input loader.
interface core_input_loader_if;
  import sha_pkg::*;

  logic        load_valid;
  logic        load_ready;
  word_t       load_word;
  logic        load_last;
  logic        out_valid;
  logic        out_newblock;
  logic        out_ready;
  hash_state_t out_hashstate;
  word_t       out_w1;
  word_t       out_w2;
  word_t       out_w3;

  modport master (
    output load_valid, load_word, load_last, out_ready,
    input  load_ready, out_valid, out_newblock, out_hashstate, out_w1, out_w2, out_w3
  );

  modport slave (
    input  load_valid, load_word, load_last, out_ready,
    output load_ready, out_valid, out_newblock, out_hashstate, out_w1, out_w2, out_w3
  );
endinterface

// File: rtl/core_input_loader_frame_deserializer.sv
// Collects 11 words into the shadow frame and flags malformed frames.
// WORD_SWAP_EN: byte-reverse every word before storage.
module frame_deserializer
  import sha_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_valid,
  input  word_t  load_word,
  input  logic   load_last,
  output logic   load_ready,
  input  logic   move,
  output logic   full,
  output frame_t frame,
  output logic   frame_err
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  load_state_e                          state, state_nxt;
  logic        [IDX_W-1:0]              idx, idx_nxt;
  logic                                 err_nxt;
  logic        [FRAME_WORDS-1:0][WORD_W-1:0] shadow;
  logic                                 xfer;
  word_t                                word_in;

`ifdef WORD_SWAP_EN
  assign word_in = little_endian_to_big(load_word);
`else
  assign word_in = load_word;
`endif

  assign load_ready = (state == LD_FILL);
  assign full       = (state == LD_FULL);
  assign xfer       = load_valid && load_ready;
  assign frame      = shadow;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = 1'b0;
    case (state)
      LD_IDLE: state_nxt = LD_FILL;
      LD_FILL: if (xfer) begin
        if (idx == LAST_IDX) begin
          idx_nxt = '0;
          if (load_last) state_nxt = LD_FULL;
          else           err_nxt   = 1'b1;
        end else if (load_last) begin
          idx_nxt = '0;
          err_nxt = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      LD_FULL: if (move) state_nxt = LD_FILL;
      default: state_nxt = LD_IDLE;
    endcase
  end

  // Slot 0 ('a') lands in the top word so the packed shadow is already a frame_t.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LD_IDLE;
      idx       <= '0;
      frame_err <= 1'b0;
      shadow    <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      frame_err <= err_nxt;
      if (xfer) shadow[LAST_IDX - idx] <= word_in;
    end
  end
endmodule

// File: rtl/core_input_loader.sv
// Double-buffered frame loader feeding the SHA-256 core.
// WORD_SWAP_EN (in the deserializer) selects byte-reversed word storage.
module core_input_loader
  import sha_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  core_input_loader_if.slave  bus,
  output logic                frame_err,
  output logic [CNT_W-1:0]    frames_accepted
);
  logic   full, move, out_valid;
  frame_t shadow_frame, active;

  frame_deserializer u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (bus.load_valid),
    .load_word  (bus.load_word),
    .load_last  (bus.load_last),
    .load_ready (bus.load_ready),
    .move       (move),
    .full       (full),
    .frame      (shadow_frame),
    .frame_err  (frame_err)
  );

  // Taking the next frame in the same cycle the core accepts gives back-to-back output.
  assign move = full && (!out_valid || bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active          <= '0;
      out_valid       <= 1'b0;
      frames_accepted <= '0;
    end else if (move) begin
      active          <= shadow_frame;
      out_valid       <= 1'b1;
      frames_accepted <= frames_accepted + 1'b1;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid;
  assign bus.out_newblock  = out_valid;
  assign bus.out_hashstate = active.hs;
  assign bus.out_w1        = active.w1;
  assign bus.out_w2        = active.w2;
  assign bus.out_w3        = active.w3;
endmodule

// File: tb/tb_core_input_loader.sv
// Self-checking bench for core_input_loader: vector table, corner sequences, random traffic.
module tb_core_input_loader;
  import sha_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_err;
  logic [15:0] frames_accepted;

  always #5 clk = ~clk;

  core_input_loader_if bus ();

  core_input_loader #(.CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .frame_err       (frame_err),
    .frames_accepted (frames_accepted)
  );

  typedef struct {
    int fsel;
    int n;
    int last_pos;
    int exp_err;
    int exp_pres;
  } vec_t;

  int           n_chk = 0;
  int           n_pass = 0;
  int           consumed = 0;
  int           err_cnt = 0;
  bit           rnd_rdy = 0;
  logic [351:0] exp_q[$];
  logic [31:0]  frames[2][11];
  logic [31:0]  fbuf[11];
  vec_t         tbl[6];

  task automatic chk(input string nm, input logic [351:0] act, input logic [351:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // The DUT swaps on storage in the swap build, so feed it the little-endian form.
  function automatic logic [31:0] feed(input logic [31:0] w);
`ifdef WORD_SWAP_EN
    return bswap(w);
`else
    return w;
`endif
  endfunction

  function automatic logic [351:0] pack_exp();
    logic [351:0] r;
    r = '0;
    for (int i = 0; i < 11; i++) r[351-32*i -: 32] = fbuf[i];
    return r;
  endfunction

  function automatic logic [351:0] cur_out();
    return {bus.out_hashstate, bus.out_w1, bus.out_w2, bus.out_w3};
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    while (!bus.load_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.load_ready) begin
      n_chk++;
      $display("FAIL load_ready_timeout: still low after %0d cycles, required high", t);
    end
  endtask

  task automatic send(input int n, input int last_pos);
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_word  = feed(fbuf[i]);
      bus.load_last  = (i + 1 == last_pos);
      wait_ready();
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic load_fbuf(input int s);
    for (int i = 0; i < 11; i++) fbuf[i] = frames[s][i];
  endtask

  task automatic monitor();
    bit           prev_hold;
    logic [351:0] prev_data;
    logic [351:0] cur;
    prev_hold = 0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 0;
        continue;
      end
      cur = cur_out();
      chk("newblock_follows_valid", 352'(bus.out_newblock), 352'(bus.out_valid));
      chk("frames_accepted", 352'(frames_accepted), 352'(16'(consumed + (bus.out_valid ? 1 : 0))));
      if (prev_hold) begin
        chk("hold_valid", 352'(bus.out_valid), 352'(1));
        chk("hold_data", cur, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_frame: got %0h, required no frame", cur);
        end else begin
          chk("frame_data", cur, exp_q.pop_front());
        end
        consumed++;
      end
      if (frame_err) err_cnt++;
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = cur;
    end
  endtask

  task automatic rand_ready();
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int           e0, c0, exp_err, exp_good, n, lp, t;
    logic [351:0] exp_a, exp_b;

    frames[0] = '{32'h9524c593, 32'h05c56713, 32'h16e669ba, 32'h2d2810a0, 32'h07e86e37,
                  32'h2f56a9da, 32'hcd5bce69, 32'h7a78da2d, 32'hf1fc122b, 32'hc7f5d74d,
                  32'hf2b9441a};
    frames[1] = '{32'h11223344, 32'hdeadbeef, 32'h0badf00d, 32'hcafebabe, 32'h01234567,
                  32'h89abcdef, 32'hfedcba98, 32'h76543210, 32'h0f0f0f0f, 32'hf0f0f0f0,
                  32'h5a5aa5a5};
    tbl[0] = '{0, 11, 11, 0, 1};
    tbl[1] = '{1, 5, 5, 1, 0};
    tbl[2] = '{0, 11, 11, 0, 1};
    tbl[3] = '{1, 11, 0, 1, 0};
    tbl[4] = '{1, 11, 11, 0, 1};
    tbl[5] = '{0, 1, 1, 1, 0};

    bus.load_valid = 1'b0;
    bus.load_word  = '0;
    bus.load_last  = 1'b0;
    bus.out_ready  = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 352'(bus.out_valid), 352'(0));
    chk("rst_load_ready", 352'(bus.load_ready), 352'(0));
    chk("rst_hashstate", 352'(bus.out_hashstate), 352'(0));
    chk("rst_frames_accepted", 352'(frames_accepted), 352'(0));
    chk("rst_frame_err", 352'(frame_err), 352'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ready_before_first_edge", 352'(bus.load_ready), 352'(0));
    @(posedge clk); #1;
    chk("ready_after_first_edge", 352'(bus.load_ready), 352'(1));

    fork
      monitor();
      rand_ready();
    join_none

    // Single frame, latency of one cycle after the last word
    bus.out_ready = 1'b1;
    load_fbuf(0);
    exp_q.push_back(pack_exp());
    send(11, 11);
    chk("lat_valid_low_T", 352'(bus.out_valid), 352'(0));
    chk("lat_full_not_ready", 352'(bus.load_ready), 352'(0));
    @(posedge clk); #1;
    chk("lat_valid_T1", 352'(bus.out_valid), 352'(1));
    chk("lat_newblock_T1", 352'(bus.out_newblock), 352'(1));
    chk("t1_hashstate", 352'(bus.out_hashstate),
        352'(256'h9524c593_05c56713_16e669ba_2d2810a0_07e86e37_2f56a9da_cd5bce69_7a78da2d));
    chk("t1_w3", 352'(bus.out_w3), 352'(32'hf2b9441a));
    chk("t1_frames_accepted", 352'(frames_accepted), 352'(1));
    repeat (2) @(posedge clk); #1;
    chk("t1_valid_dropped", 352'(bus.out_valid), 352'(0));

    // Backpressure: two frames, core stalled
    bus.out_ready = 1'b0;
    load_fbuf(1);
    exp_a = pack_exp();
    exp_q.push_back(exp_a);
    send(11, 11);
    load_fbuf(0);
    fbuf[10] = 32'h00c0ffee;
    exp_b = pack_exp();
    exp_q.push_back(exp_b);
    send(11, 11);
    @(posedge clk); #1;
    chk("bp_load_ready_low", 352'(bus.load_ready), 352'(0));
    chk("bp_frame1_held", cur_out(), exp_a);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_frame2_valid", 352'(bus.out_valid), 352'(1));
    chk("bp_frame2_data", cur_out(), exp_b);
    chk("bp_load_ready_back", 352'(bus.load_ready), 352'(1));
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Vector table: well-formed and malformed frames with the core always ready
    for (int v = 0; v < 6; v++) begin
      load_fbuf(tbl[v].fsel);
      e0 = err_cnt;
      c0 = consumed;
      if (tbl[v].exp_pres != 0) exp_q.push_back(pack_exp());
      send(tbl[v].n, tbl[v].last_pos);
      repeat (4) @(posedge clk); #1;
      chk($sformatf("vec%0d_err", v), 352'(err_cnt - e0), 352'(tbl[v].exp_err));
      chk($sformatf("vec%0d_presented", v), 352'(consumed - c0), 352'(tbl[v].exp_pres));
      chk($sformatf("vec%0d_accepted", v), 352'(frames_accepted), 352'(16'(consumed)));
    end

    // Reset mid-frame
    load_fbuf(1);
    send(6, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 352'(bus.out_valid), 352'(0));
    chk("mid_rst_newblock", 352'(bus.out_newblock), 352'(0));
    chk("mid_rst_ready", 352'(bus.load_ready), 352'(0));
    chk("mid_rst_data", cur_out(), 352'(0));
    chk("mid_rst_accepted", 352'(frames_accepted), 352'(0));
    exp_q.delete();
    consumed = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_no_err", 352'(frame_err), 352'(0));
    e0 = err_cnt;
    load_fbuf(0);
    exp_q.push_back(pack_exp());
    send(11, 11);
    repeat (4) @(posedge clk); #1;
    chk("post_rst_presented", 352'(consumed), 352'(1));
    chk("post_rst_err", 352'(err_cnt - e0), 352'(0));

    // Random traffic with random core readiness
    e0 = err_cnt;
    exp_err = 0;
    exp_good = consumed;
    rnd_rdy = 1;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 11; i++) fbuf[i] = $urandom;
      case ($urandom_range(0, 9))
        0: begin n = $urandom_range(1, 10); lp = n; exp_err++; end
        1: begin n = 11; lp = 0; exp_err++; end
        default: begin n = 11; lp = 11; exp_good++; exp_q.push_back(pack_exp()); end
      endcase
      send(n, lp);
    end
    rnd_rdy = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (2) @(posedge clk); #1;
    chk("rnd_queue_drained", 352'(exp_q.size()), 352'(0));
    chk("rnd_errors", 352'(err_cnt - e0), 352'(exp_err));
    chk("rnd_accepted", 352'(frames_accepted), 352'(16'(exp_good)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
